// File: rtl/arith_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : arith_seq_unit
// Description : Handshaked ALU; single-cycle ADD/SUB/logic/NEG, iterative MUL/DIV.
//               Optional saturation of ADD/SUB/MUL when ARITH_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_seq_unit #(
  parameter int WIDTH_M = 8,
  parameter int WIDTH_N = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH_M-1:0] i_arg_A,
  input  logic [WIDTH_M-1:0] i_arg_B,
  input  logic [WIDTH_N-1:0] i_op,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH_M-1:0] o_result,
  output logic [3:0]         o_status
);

  localparam int CW = $clog2(WIDTH_M);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH_M - 1);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_NEG = 3'b101;
  localparam logic [2:0] c_OP_MUL = 3'b110;
  localparam logic [2:0] c_OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0]          r_cnt;
  logic                   r_is_mul;
  logic [WIDTH_M-1:0]     r_result;
  logic [3:0]             r_status;

  logic [2*WIDTH_M-1:0]   r_mcand;
  logic [WIDTH_M-1:0]     r_mplier;
  logic [2*WIDTH_M-1:0]   r_prod;
  logic [WIDTH_M-1:0]     r_quo;
  logic [WIDTH_M-1:0]     r_rem;
  logic [WIDTH_M-1:0]     r_div;

  logic                   w_op_hi_err;
  logic                   w_accept;
  logic                   w_go_busy;
  logic                   w_cnt_last;
  logic [WIDTH_M:0]       w_sum;
  logic [WIDTH_M:0]       w_diff;
  logic [WIDTH_M-1:0]     w_one_res;
  logic                   w_one_flag;
  logic                   w_one_err;

  logic [2*WIDTH_M-1:0]   w_prod_nx;
  logic [WIDTH_M:0]       w_rem_sh;
  logic [WIDTH_M:0]       w_rem_try;
  logic                   w_quo_bit;
  logic [WIDTH_M-1:0]     w_rem_nx;
  logic [WIDTH_M-1:0]     w_quo_nx;
  logic                   w_mul_ovf;
  logic [WIDTH_M-1:0]     w_busy_res;
  logic                   w_busy_flag;

  function automatic logic [3:0] f_status(input logic [WIDTH_M-1:0] res,
                                          input logic flag, input logic err);
    f_status = {err, flag, res[WIDTH_M-1], ~|res};
  endfunction

  // Opcode bits above [2] only exist for wider opcode fields
  generate
    if (WIDTH_N > 3) begin : g_op_hi
      assign w_op_hi_err = |i_op[WIDTH_N-1:3];
    end else begin : g_op_no_hi
      assign w_op_hi_err = 1'b0;
    end
  endgenerate

  assign w_accept   = i_valid && (r_state == S_IDLE);
  assign w_cnt_last = (r_cnt == c_CNT_LAST);
  assign w_go_busy  = !w_op_hi_err &&
                      ((i_op[2:0] == c_OP_MUL) ||
                       ((i_op[2:0] == c_OP_DIV) && (|i_arg_B)));

  always_comb begin
    w_sum      = {1'b0, i_arg_A} + {1'b0, i_arg_B};
    w_diff     = {1'b0, i_arg_A} - {1'b0, i_arg_B};
    w_one_res  = '0;
    w_one_flag = 1'b0;
    w_one_err  = 1'b0;
    if (w_op_hi_err) begin
      w_one_err = 1'b1;
    end else begin
      case (i_op[2:0])
        c_OP_ADD: begin
          w_one_res  = w_sum[WIDTH_M-1:0];
          w_one_flag = w_sum[WIDTH_M];
`ifdef ARITH_SAT_EN
          if (w_sum[WIDTH_M]) w_one_res = '1;
`endif
        end
        c_OP_SUB: begin
          w_one_res  = w_diff[WIDTH_M-1:0];
          w_one_flag = w_diff[WIDTH_M];
`ifdef ARITH_SAT_EN
          if (w_diff[WIDTH_M]) w_one_res = '0;
`endif
        end
        c_OP_AND: w_one_res = i_arg_A & i_arg_B;
        c_OP_OR:  w_one_res = i_arg_A | i_arg_B;
        c_OP_XOR: w_one_res = i_arg_A ^ i_arg_B;
        c_OP_NEG: w_one_res = '0 - i_arg_A;
        c_OP_MUL: w_one_res = '0;
        c_OP_DIV: begin
          // Only reached here for a zero divisor
          w_one_res = '1;
          w_one_err = 1'b1;
        end
      endcase
    end
  end

  // One shift-add / restoring-division step per BUSY cycle
  assign w_prod_nx = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_rem_sh  = {r_rem, r_quo[WIDTH_M-1]};
  assign w_rem_try = w_rem_sh - {1'b0, r_div};
  assign w_quo_bit = ~w_rem_try[WIDTH_M];
  assign w_rem_nx  = w_quo_bit ? w_rem_try[WIDTH_M-1:0] : w_rem_sh[WIDTH_M-1:0];
  assign w_quo_nx  = {r_quo[WIDTH_M-2:0], w_quo_bit};
  assign w_mul_ovf = |w_prod_nx[2*WIDTH_M-1:WIDTH_M];

  always_comb begin
    w_busy_res  = w_quo_nx;
    w_busy_flag = 1'b0;
    if (r_is_mul) begin
      w_busy_res  = w_prod_nx[WIDTH_M-1:0];
      w_busy_flag = w_mul_ovf;
`ifdef ARITH_SAT_EN
      if (w_mul_ovf) w_busy_res = '1;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) w_state_nx = w_go_busy ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (w_cnt_last) w_state_nx = S_DONE;
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_result <= '0;
      r_status <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_mul <= (i_op[2:0] == c_OP_MUL);
      r_mcand  <= {{WIDTH_M{1'b0}}, i_arg_A};
      r_mplier <= i_arg_B;
      r_prod   <= '0;
      r_quo    <= i_arg_A;
      r_rem    <= '0;
      r_div    <= i_arg_B;
      if (!w_go_busy) begin
        r_result <= w_one_res;
        r_status <= f_status(w_one_res, w_one_flag, w_one_err);
      end
    end else if (r_state == S_BUSY) begin
      r_cnt    <= r_cnt + CW'(1);
      r_mcand  <= {r_mcand[2*WIDTH_M-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH_M-1:1]};
      r_prod   <= w_prod_nx;
      r_quo    <= w_quo_nx;
      r_rem    <= w_rem_nx;
      if (w_cnt_last) begin
        r_result <= w_busy_res;
        r_status <= f_status(w_busy_res, w_busy_flag, 1'b0);
      end
    end
  end

  assign o_result = r_result;
  assign o_status = r_status;

endmodule
`default_nettype wire

// File: tb/tb_arith_seq_unit.sv
`default_nettype none
// Testbench for arith_seq_unit (WIDTH_M=4, WIDTH_N=3) with a queue-based scoreboard.
module tb_arith_seq_unit;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] st;
    logic [7:0] lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_valid;
  logic       o_ready;
  logic [3:0] i_arg_A;
  logic [3:0] i_arg_B;
  logic [2:0] i_op;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_result;
  logic [3:0] o_status;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  arith_seq_unit #(.WIDTH_M(4), .WIDTH_N(3)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_arg_A (i_arg_A),
    .i_arg_B (i_arg_B),
    .i_op    (i_op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_status(o_status)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    logic [4:0] s;
    logic [7:0] p;
    logic c, err;
    c = 1'b0; err = 1'b0; e.lat = 8'd1; e.res = 4'd0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[3:0]; c = s[4]; end
      3'd1: begin e.res = a - b; c = (a < b); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = 4'd0 - a;
      3'd6: begin p = {4'd0, a} * {4'd0, b}; e.res = p[3:0]; c = |p[7:4]; e.lat = 8'd5; end
      3'd7: begin
        if (b == 4'd0) begin e.res = 4'hF; err = 1'b1; end
        else begin e.res = a / b; e.lat = 8'd5; end
      end
    endcase
`ifdef ARITH_SAT_EN
    if (c && (op == 3'd0 || op == 3'd6)) e.res = 4'hF;
    if (c && op == 3'd1) e.res = 4'd0;
`endif
    e.st = {err, c, e.res[3], (e.res == 4'd0)};
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input exp_t e);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    i_arg_A = a; i_arg_B = b; i_op = op; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_vec++; if (o_result !== 4'd0) begin n_err++; $display("FAIL reset_result: got %b expected 0000", o_result); end
    n_vec++; if (o_status !== 4'd0) begin n_err++; $display("FAIL reset_status: got %b expected 0000", o_status); end
    i_reset = 1'b1;
  endtask

  task automatic test_add;
    exp_t e;
    int lat;
`ifdef ARITH_SAT_EN
    issue(4'b1110, 4'b0011, 3'd0, '{res: 4'b1111, st: 4'b0110, lat: 8'd1});
`else
    issue(4'b1110, 4'b0011, 3'd0, '{res: 4'b0001, st: 4'b0100, lat: 8'd1});
`endif
    wait_valid(lat);
    e = sb.pop_front();
    n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL add_result: got %b expected %b", o_result, e.res); end
    n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL add_status: got %b expected %b", o_status, e.st); end
    n_vec++; if (lat != int'(e.lat)) begin n_err++; $display("FAIL add_latency: got %0d expected %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [3:0] ta[2] = '{4'b0101, 4'b0101};
    logic [3:0] tb[2] = '{4'b0011, 4'b0100};
    exp_t te[2];
    exp_t e;
    int lat;
    te[0] = '{res: 4'b1111, st: 4'b0010, lat: 8'd5};
`ifdef ARITH_SAT_EN
    te[1] = '{res: 4'b1111, st: 4'b0110, lat: 8'd5};
`else
    te[1] = '{res: 4'b0100, st: 4'b0100, lat: 8'd5};
`endif
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], 3'd6, te[i]);
      wait_valid(lat);
      e = sb.pop_front();
      n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL mul%0d_result: got %b expected %b", i, o_result, e.res); end
      n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL mul%0d_status: got %b expected %b", i, o_status, e.st); end
      n_vec++; if (lat != int'(e.lat)) begin n_err++; $display("FAIL mul%0d_latency: got %0d expected %0d", i, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div;
    logic [3:0] ta[2] = '{4'b1101, 4'b1011};
    logic [3:0] tb[2] = '{4'b0011, 4'b0000};
    exp_t te[2];
    exp_t e;
    int lat;
    te[0] = '{res: 4'b0100, st: 4'b0000, lat: 8'd5};
    te[1] = '{res: 4'b1111, st: 4'b1010, lat: 8'd1};
    for (int i = 0; i < 2; i++) begin
      issue(ta[i], tb[i], 3'd7, te[i]);
      wait_valid(lat);
      e = sb.pop_front();
      n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL div%0d_result: got %b expected %b", i, o_result, e.res); end
      n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL div%0d_status: got %b expected %b", i, o_status, e.st); end
      n_vec++; if (lat != int'(e.lat)) begin n_err++; $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  // Relies on the previous test leaving a nonzero result behind
  task automatic test_reset_mid_div;
    exp_t e;
    int lat;
    issue(4'b1101, 4'b0011, 3'd7, '{res: 4'b0100, st: 4'b0000, lat: 8'd5});
    @(posedge clk); #3;
    i_reset = 1'b0;
    #1;
    sb.delete();
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rstdiv_valid: got %b expected 0", o_valid); end
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rstdiv_ready: got %b expected 1", o_ready); end
    n_vec++; if (o_result !== 4'd0) begin n_err++; $display("FAIL rstdiv_result: got %b expected 0000", o_result); end
    n_vec++; if (o_status !== 4'd0) begin n_err++; $display("FAIL rstdiv_status: got %b expected 0000", o_status); end
    @(posedge clk); #1;
    i_reset = 1'b1;
    issue(4'b1101, 4'b0011, 3'd7, model(4'b1101, 4'b0011, 3'd7));
    wait_valid(lat);
    e = sb.pop_front();
    n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL rstdiv_after_result: got %b expected %b", o_result, e.res); end
    n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL rstdiv_after_status: got %b expected %b", o_status, e.st); end
    n_vec++; if (lat != int'(e.lat)) begin n_err++; $display("FAIL rstdiv_after_latency: got %0d expected %0d", lat, e.lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    exp_t e;
    int lat;
    i_ready = 1'b0;
    issue(4'b0010, 4'b0010, 3'd1, '{res: 4'b0000, st: 4'b0001, lat: 8'd1});
    wait_valid(lat);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d_valid: got %b expected 1", i, o_valid); end
      n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp%0d_ready: got %b expected 0", i, o_ready); end
      n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL bp%0d_result: got %b expected %b", i, o_result, e.res); end
      n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL bp%0d_status: got %b expected %b", i, o_status, e.st); end
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", o_ready); end
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", o_valid); end
  endtask

  task automatic test_ignored_inputs;
    exp_t e;
    int lat;
    issue(4'b0101, 4'b0011, 3'd6, model(4'b0101, 4'b0011, 3'd6));
    i_valid = 1'b1;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 40) begin
      i_arg_A = 4'($urandom); i_arg_B = 4'($urandom); i_op = 3'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    i_valid = 1'b0;
    e = sb.pop_front();
    n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL ign_result: got %b expected %b", o_result, e.res); end
    n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL ign_status: got %b expected %b", o_status, e.st); end
    n_vec++; if (lat != int'(e.lat)) begin n_err++; $display("FAIL ign_latency: got %0d expected %0d", lat, e.lat); end
    @(posedge clk); #1;
    issue(4'b0000, 4'b1010, 3'd5, '{res: 4'b0000, st: 4'b0001, lat: 8'd1});
    wait_valid(lat);
    e = sb.pop_front();
    n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL neg0_result: got %b expected %b", o_result, e.res); end
    n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL neg0_status: got %b expected %b", o_status, e.st); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [3:0] a, b;
    logic [2:0] op;
    exp_t e;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom); b = 4'($urandom); op = 3'(i % 8);
      issue(a, b, op, model(a, b, op));
      wait_valid(lat);
      e = sb.pop_front();
      n_vec++; if (o_result !== e.res) begin n_err++; $display("FAIL b2b%0d_result op=%0d a=%b b=%b: got %b expected %b", i, op, a, b, o_result, e.res); end
      n_vec++; if (o_status !== e.st) begin n_err++; $display("FAIL b2b%0d_status op=%0d a=%b b=%b: got %b expected %b", i, op, a, b, o_status, e.st); end
      n_vec++; if (lat != int'(e.lat)) begin n_err++; $display("FAIL b2b%0d_latency op=%0d: got %0d expected %0d", i, op, lat, e.lat); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_arg_A = 4'd0; i_arg_B = 4'd0; i_op = 3'd0;
    @(posedge clk); #1;
    test_reset;
    test_add;
    test_mul;
    test_div;
    test_reset_mid_div;
    test_backpressure;
    test_ignored_inputs;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
